vrf_rd_seq: RTL and testbench

//  Read-side sequencer for the vector register file (vrf). Accepts one command naming two

---
 rtl/vrf_pkg.sv | 33 +++
 rtl/vrf_rd_addr_gen.sv | 29 ++
 rtl/vrf_rd_seq.sv | 182 ++++++++++++++++++
 tb/tb_vrf_rd_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared vector register file geometry, read-command format and read-sequencer states.
// With VRF_RD_SEQ_MASK_EN defined, the command also carries an active-element count (vl).
package vrf_pkg;

    localparam int vrf_els_lp        = 32;
    localparam int vrf_vlen_lp       = 8;
    localparam int vrf_vdw_lp        = 32;
    localparam int vrf_lanes_lp      = 4;
    localparam int vrf_v_addr_w_lp   = $clog2(vrf_els_lp);
    localparam int vrf_local_addr_lp = $clog2(vrf_vlen_lp);
    localparam int vrf_addr_w_lp     = vrf_v_addr_w_lp + vrf_local_addr_lp;
    localparam int vrf_vl_w_lp       = $clog2(vrf_vlen_lp + 1);

    typedef struct packed {
        logic [vrf_v_addr_w_lp-1:0] vs1;
        logic [vrf_v_addr_w_lp-1:0] vs2;
`ifdef VRF_RD_SEQ_MASK_EN
        logic [vrf_vl_w_lp-1:0]     vl;
`endif
    } vrf_rd_cmd_s;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } vrf_rd_state_e;

    // Number of beats needed to cover n elements, lanes elements per beat.
    function automatic int vrf_beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/vrf_rd_addr_gen.sv
// Turns a vector bank and beat index into per-lane {bank, element} read addresses.
// Outputs are forced to zero when not enabled so idle ports present a clean address.
module vrf_rd_addr_gen
    import vrf_pkg::*;
#(
    parameter int lanes_p            = vrf_lanes_lp,
    parameter int v_addr_width_p     = vrf_v_addr_w_lp,
    parameter int local_addr_width_p = vrf_local_addr_lp,
    parameter int cnt_width_p        = 1
) (
    input  logic                                                    i_en,
    input  logic [v_addr_width_p-1:0]                               i_bank,
    input  logic [cnt_width_p-1:0]                                  i_beat,
    output logic [lanes_p*(v_addr_width_p+local_addr_width_p)-1:0]  o_addr
);

    localparam int addr_width_lp = v_addr_width_p + local_addr_width_p;

    always_comb begin
        o_addr = '0;
        if (i_en) begin
            for (int i = 0; i < lanes_p; i++) begin
                o_addr[i*addr_width_lp +: addr_width_lp] =
                    {i_bank, local_addr_width_p'(int'(i_beat) * lanes_p + i)};
            end
        end
    end

endmodule

// File: rtl/vrf_rd_seq.sv
// Vector register file read sequencer: one command -> beats of lanes_p operand pairs, valid/yumi out.
// Optional VRF_RD_SEQ_MASK_EN adds cmd_vl_i (active element count) and data_mask_o.
module vrf_rd_seq
    import vrf_pkg::*;
#(
    parameter int els_p   = vrf_els_lp,
    parameter int vlen_p  = vrf_vlen_lp,
    parameter int vdw_p   = vrf_vdw_lp,
    parameter int lanes_p = vrf_lanes_lp
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic                                            cmd_v_i,
    input  logic [$clog2(els_p)-1:0]                        cmd_vs1_i,
    input  logic [$clog2(els_p)-1:0]                        cmd_vs2_i,
`ifdef VRF_RD_SEQ_MASK_EN
    input  logic [$clog2(vlen_p+1)-1:0]                     cmd_vl_i,
    output logic [lanes_p-1:0]                              data_mask_o,
`endif
    output logic                                            cmd_ready_o,
    output logic [lanes_p*($clog2(els_p)+$clog2(vlen_p))-1:0] r0_addr_o,
    output logic [lanes_p*($clog2(els_p)+$clog2(vlen_p))-1:0] r1_addr_o,
    input  logic [lanes_p*vdw_p-1:0]                        r0_data_i,
    input  logic [lanes_p*vdw_p-1:0]                        r1_data_i,
    output logic                                            data_v_o,
    output logic [lanes_p*vdw_p-1:0]                        op0_o,
    output logic [lanes_p*vdw_p-1:0]                        op1_o,
    output logic                                            last_o,
    input  logic                                            data_yumi_i
);

    localparam int v_addr_width_lp     = $clog2(els_p);
    localparam int local_addr_width_lp = $clog2(vlen_p);
    localparam int addr_width_lp       = v_addr_width_lp + local_addr_width_lp;
    localparam int beats_lp            = vlen_p / lanes_p;
    localparam int cnt_width_lp        = (beats_lp > 1) ? $clog2(beats_lp) : 1;

    vrf_rd_state_e             r_state;
    vrf_rd_state_e             w_stateNext;
    vrf_rd_cmd_s               r_cmd;
    logic [cnt_width_lp-1:0]   r_beat;
    logic [cnt_width_lp-1:0]   w_lastBeat;
    logic                      r_dataV;
    logic                      r_last;
    logic [lanes_p*vdw_p-1:0]  r_op0;
    logic [lanes_p*vdw_p-1:0]  r_op1;
    logic                      w_cmdReady;
    logic                      w_accept;
    logic                      w_capture;
    logic                      w_addrEn;
    logic                      w_isLastBeat;
    logic                      w_cmdEmpty;

`ifdef VRF_RD_SEQ_MASK_EN
    localparam int vl_width_lp = $clog2(vlen_p + 1);

    logic [vl_width_lp-1:0]    w_vlClamped;
    logic [cnt_width_lp-1:0]   w_lastBeatIn;
    logic [cnt_width_lp-1:0]   r_lastBeat;
    logic [lanes_p-1:0]        w_maskNext;
    logic [lanes_p-1:0]        r_mask;

    // Oversized vl saturates to a full vector; vl=0 is accepted but never leaves IDLE.
    always_comb begin
        w_vlClamped  = (cmd_vl_i > vl_width_lp'(vlen_p)) ? vl_width_lp'(vlen_p) : cmd_vl_i;
        w_lastBeatIn = cnt_width_lp'(vrf_beats(int'(w_vlClamped), lanes_p) - 1);
        w_cmdEmpty   = (w_vlClamped == '0);
        w_maskNext   = '0;
        for (int i = 0; i < lanes_p; i++) begin
            w_maskNext[i] = (int'(r_beat) * lanes_p + i) < int'(r_cmd.vl);
        end
    end

    assign w_lastBeat  = r_lastBeat;
    assign data_mask_o = r_mask;
`else
    assign w_lastBeat  = cnt_width_lp'(beats_lp - 1);
    assign w_cmdEmpty  = 1'b0;
`endif

    assign w_accept     = cmd_v_i & w_cmdReady;
    assign w_isLastBeat = (r_beat == w_lastBeat);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_cmdEmpty)      w_stateNext = ISSUE;
            ISSUE:   if (w_capture && w_isLastBeat)    w_stateNext = DRAIN;
            DRAIN:   if (data_yumi_i)                  w_stateNext = IDLE;
            default:                                   w_stateNext = IDLE;
        endcase
    end

    // A beat is issued whenever the single output register is empty or being emptied.
    always_comb begin
        w_cmdReady = (r_state == IDLE);
        w_addrEn   = (r_state == ISSUE);
        w_capture  = (r_state == ISSUE) && (!r_dataV || data_yumi_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cmd   <= '0;
            r_beat  <= '0;
            r_dataV <= 1'b0;
            r_last  <= 1'b0;
            r_op0   <= '0;
            r_op1   <= '0;
`ifdef VRF_RD_SEQ_MASK_EN
            r_lastBeat <= '0;
            r_mask     <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_cmd.vs1 <= cmd_vs1_i;
                r_cmd.vs2 <= cmd_vs2_i;
                r_beat    <= '0;
`ifdef VRF_RD_SEQ_MASK_EN
                r_cmd.vl   <= w_vlClamped;
                r_lastBeat <= w_lastBeatIn;
`endif
            end else if (w_capture && !w_isLastBeat) begin
                r_beat <= r_beat + 1'b1;
            end

            if (w_capture) begin
                r_op0   <= r0_data_i;
                r_op1   <= r1_data_i;
                r_last  <= w_isLastBeat;
                r_dataV <= 1'b1;
`ifdef VRF_RD_SEQ_MASK_EN
                r_mask  <= w_maskNext;
`endif
            end else if (data_yumi_i) begin
                r_dataV <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    vrf_rd_addr_gen #(
        .lanes_p            (lanes_p),
        .v_addr_width_p     (v_addr_width_lp),
        .local_addr_width_p (local_addr_width_lp),
        .cnt_width_p        (cnt_width_lp)
    ) u_addrGen0 (
        .i_en   (w_addrEn),
        .i_bank (r_cmd.vs1),
        .i_beat (r_beat),
        .o_addr (r0_addr_o)
    );

    vrf_rd_addr_gen #(
        .lanes_p            (lanes_p),
        .v_addr_width_p     (v_addr_width_lp),
        .local_addr_width_p (local_addr_width_lp),
        .cnt_width_p        (cnt_width_lp)
    ) u_addrGen1 (
        .i_en   (w_addrEn),
        .i_bank (r_cmd.vs2),
        .i_beat (r_beat),
        .o_addr (r1_addr_o)
    );

    assign cmd_ready_o = w_cmdReady;
    assign data_v_o    = r_dataV;
    assign op0_o       = r_op0;
    assign op1_o       = r_op1;
    assign last_o      = r_last;

    assert property (@(posedge clk_i) disable iff (reset_i) data_yumi_i |-> r_dataV)
        else $fatal(1, "vrf_rd_seq: data_yumi_i asserted without data_v_o");

endmodule

// File: tb/tb_vrf_rd_seq.sv
// Randomized bench for vrf_rd_seq against a beat-queue model of the read sequencer.
// Builds with or without VRF_RD_SEQ_MASK_EN; mask checks are included only when it is defined.
module tb_vrf_rd_seq;

    localparam int LANES = 4;
    localparam int VDW   = 32;
    localparam int AW    = 8;
    localparam int VLEN  = 8;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 cmd_v_i;
    logic [4:0]           cmd_vs1_i;
    logic [4:0]           cmd_vs2_i;
    logic                 cmd_ready_o;
    logic [LANES*AW-1:0]  r0_addr_o;
    logic [LANES*AW-1:0]  r1_addr_o;
    logic [LANES*VDW-1:0] r0_data_i;
    logic [LANES*VDW-1:0] r1_data_i;
    logic                 data_v_o;
    logic [LANES*VDW-1:0] op0_o;
    logic [LANES*VDW-1:0] op1_o;
    logic                 last_o;
    logic                 data_yumi_i;
`ifdef VRF_RD_SEQ_MASK_EN
    logic [3:0]           cmd_vl_i;
    logic [3:0]           data_mask_o;
`endif

    logic [31:0] mem [32][8];

    typedef struct {
        logic [LANES*VDW-1:0] op0;
        logic [LANES*VDW-1:0] op1;
        logic                 last;
        logic [3:0]           mask;
    } beat_t;

    beat_t expQ[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cycle       = 0;
    int    nextPresent = 0;

    vrf_rd_seq dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cmd_v_i     (cmd_v_i),
        .cmd_vs1_i   (cmd_vs1_i),
        .cmd_vs2_i   (cmd_vs2_i),
`ifdef VRF_RD_SEQ_MASK_EN
        .cmd_vl_i    (cmd_vl_i),
        .data_mask_o (data_mask_o),
`endif
        .cmd_ready_o (cmd_ready_o),
        .r0_addr_o   (r0_addr_o),
        .r1_addr_o   (r1_addr_o),
        .r0_data_i   (r0_data_i),
        .r1_data_i   (r1_data_i),
        .data_v_o    (data_v_o),
        .op0_o       (op0_o),
        .op1_o       (op1_o),
        .last_o      (last_o),
        .data_yumi_i (data_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Combinational register file read, addresses are {bank[4:0], element[2:0]}.
    always_comb begin
        r0_data_i = '0;
        r1_data_i = '0;
        for (int i = 0; i < LANES; i++) begin
            r0_data_i[i*VDW +: VDW] = mem[r0_addr_o[i*AW+3 +: 5]][r0_addr_o[i*AW +: 3]];
            r1_data_i[i*VDW +: VDW] = mem[r1_addr_o[i*AW+3 +: 5]][r1_addr_o[i*AW +: 3]];
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cycle, obs, exp);
        end
    endtask

    // Reference: a command becomes a list of beats, element e of vector v read as mem[v][e].
    task automatic pushCommand(input logic [4:0] vs1, input logic [4:0] vs2, input int vl);
        int    n;
        int    nb;
        int    el;
        beat_t bt;
`ifdef VRF_RD_SEQ_MASK_EN
        n = (vl > VLEN) ? VLEN : vl;
`else
        n = VLEN;
`endif
        nb = (n + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            bt.op0  = '0;
            bt.op1  = '0;
            bt.mask = '0;
            for (int i = 0; i < LANES; i++) begin
                el = b * LANES + i;
                bt.op0[i*VDW +: VDW] = mem[vs1][el];
                bt.op1[i*VDW +: VDW] = mem[vs2][el];
                bt.mask[i]           = (el < n);
            end
            bt.last = (b == nb - 1);
            expQ.push_back(bt);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, drive inputs, advance the model.
    task automatic applyStimulus(input logic cmdV, input logic [4:0] vs1, input logic [4:0] vs2,
                                 input int vl, input logic yumiReq);
        logic expV;
        expV = (expQ.size() > 0) && (cycle >= nextPresent);
        checkOutput("cmd_ready", 128'(cmd_ready_o), 128'(expQ.size() == 0));
        checkOutput("data_v", 128'(data_v_o), 128'(expV));
        if (expV && data_v_o) begin
            checkOutput("op0", op0_o, expQ[0].op0);
            checkOutput("op1", op1_o, expQ[0].op1);
            checkOutput("last", 128'(last_o), 128'(expQ[0].last));
`ifdef VRF_RD_SEQ_MASK_EN
            checkOutput("mask", 128'(data_mask_o), 128'(expQ[0].mask));
`endif
        end
        cmd_v_i     = cmdV;
        cmd_vs1_i   = vs1;
        cmd_vs2_i   = vs2;
`ifdef VRF_RD_SEQ_MASK_EN
        cmd_vl_i    = 4'(vl);
`endif
        data_yumi_i = yumiReq && data_v_o && expV;
        if (cmdV && expQ.size() == 0) begin
            pushCommand(vs1, vs2, vl);
            nextPresent = cycle + 2;
        end else if (data_yumi_i) begin
            void'(expQ.pop_front());
            nextPresent = cycle + 1;
        end
        @(negedge clk_i);
        cycle++;
        cmd_v_i     = 1'b0;
        data_yumi_i = 1'b0;
    endtask

    task automatic idleCycles(input int n, input logic yumiReq);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 5'd0, 5'd0, VLEN, yumiReq);
    endtask

    initial begin
        reset_i     = 1'b1;
        cmd_v_i     = 1'b0;
        cmd_vs1_i   = '0;
        cmd_vs2_i   = '0;
        data_yumi_i = 1'b0;
`ifdef VRF_RD_SEQ_MASK_EN
        cmd_vl_i    = '0;
`endif
        for (int b = 0; b < 32; b++)
            for (int e = 0; e < 8; e++) mem[b][e] = 32'(b * 16 + e);

        // Reset state
        repeat (2) @(negedge clk_i);
        checkOutput("rst_ready", 128'(cmd_ready_o), 128'd1);
        checkOutput("rst_data_v", 128'(data_v_o), 128'd0);
        checkOutput("rst_last", 128'(last_o), 128'd0);
        checkOutput("rst_op0", op0_o, 128'd0);
        checkOutput("rst_r0_addr", 128'(r0_addr_o), 128'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        idleCycles(2, 1'b1);

        // Full-throughput command with the bank*16+idx pattern
        applyStimulus(1'b1, 5'd3, 5'd5, VLEN, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("t2_op0_b0", op0_o, 128'h00000033_00000032_00000031_00000030);
        checkOutput("t2_op1_b0", op1_o, 128'h00000053_00000052_00000051_00000050);
        idleCycles(1, 1'b1);
        checkOutput("t2_op0_b1", op0_o, 128'h00000037_00000036_00000035_00000034);
        checkOutput("t2_last_b1", 128'(last_o), 128'd1);
        idleCycles(3, 1'b1);

        // Backpressure: beat 0 held, next-beat addresses stable
        applyStimulus(1'b1, 5'd3, 5'd5, VLEN, 1'b0);
        idleCycles(3, 1'b0);
        checkOutput("t3_r0_addr_l0", 128'(r0_addr_o[7:0]), 128'(8'b00011_100));
        checkOutput("t3_r1_addr_l3", 128'(r1_addr_o[31:24]), 128'(8'b00101_111));
        idleCycles(3, 1'b0);
        idleCycles(5, 1'b1);

        // Command pulsed while busy must be ignored
        applyStimulus(1'b1, 5'd3, 5'd5, VLEN, 1'b1);
        applyStimulus(1'b1, 5'd7, 5'd9, VLEN, 1'b1);
        idleCycles(4, 1'b1);

        // Reset in the middle of a command
        applyStimulus(1'b1, 5'd3, 5'd5, VLEN, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("t5_v_before", 128'(data_v_o), 128'd1);
        reset_i = 1'b1;
        #1;
        checkOutput("t5_v_in_reset", 128'(data_v_o), 128'd0);
        checkOutput("t5_op0_in_reset", op0_o, 128'd0);
        checkOutput("t5_last_in_reset", 128'(last_o), 128'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        expQ.delete();
        cycle++;
        @(negedge clk_i);
        cycle++;
        checkOutput("t5_ready_after", 128'(cmd_ready_o), 128'd1);
        idleCycles(2, 1'b1);

`ifdef VRF_RD_SEQ_MASK_EN
        // Partial vector and empty vector
        applyStimulus(1'b1, 5'd4, 5'd6, 5, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("t6_mask_b0", 128'(data_mask_o), 128'(4'b1111));
        idleCycles(1, 1'b1);
        checkOutput("t6_mask_b1", 128'(data_mask_o), 128'(4'b0001));
        idleCycles(2, 1'b1);
        applyStimulus(1'b1, 5'd4, 5'd6, 0, 1'b1);
        idleCycles(3, 1'b1);
        applyStimulus(1'b1, 5'd8, 5'd2, 15, 1'b1);
        idleCycles(5, 1'b1);
`endif

        // Randomized commands, data and backpressure
        for (int b = 0; b < 32; b++)
            for (int e = 0; e < 8; e++) mem[b][e] = $urandom;
        for (int k = 0; k < 600; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                          int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        idleCycles(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
